// File: rtl/ram_arbiter.sv
// Round-robin share of one single-port RAM between two clients: grant in the request cycle, read data one cycle later.
// ram_delay withholds the grant and pins the stalled access to its client until the RAM accepts it.
module ram_arbiter #(
   parameter  int ADDR_WIDTH = 32,
   parameter  int DATA_WIDTH = 32,
   localparam int NUM_BYTES  = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_c0_req,
   input  logic                  i_c0_we,
   input  logic [ADDR_WIDTH-1:0] i_c0_addr,
   input  logic [NUM_BYTES-1:0]  i_c0_be,
   input  logic [DATA_WIDTH-1:0] i_c0_wdata,
   input  logic                  i_c1_req,
   input  logic                  i_c1_we,
   input  logic [ADDR_WIDTH-1:0] i_c1_addr,
   input  logic [NUM_BYTES-1:0]  i_c1_be,
   input  logic [DATA_WIDTH-1:0] i_c1_wdata,
   output logic                  o_c0_gnt,
   output logic                  o_c1_gnt,
   output logic                  o_c0_rvalid,
   output logic                  o_c1_rvalid,
   output logic [DATA_WIDTH-1:0] o_c0_rdata,
   output logic [DATA_WIDTH-1:0] o_c1_rdata,
   output logic                  o_ram_en,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [NUM_BYTES-1:0]  o_ram_be,
   output logic [DATA_WIDTH-1:0] o_ram_data_w,
   input  logic [DATA_WIDTH-1:0] i_ram_data_r,
   input  logic                  i_ram_delay
);

   logic r_last;
   logic r_lock;
   logic r_lock_id;
   logic r_rv0;
   logic r_rv1;

   logic w_sel_vld;
   logic w_sel_id;
   logic w_sel_we;
   logic w_gnt;

   // A locked (stalled) access beats fresh arbitration so requests are never reordered.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_id  = 1'b0;
      if (i_reset) begin
         w_sel_vld = 1'b0;
      end else if (r_lock) begin
         w_sel_vld = 1'b1;
         w_sel_id  = r_lock_id;
      end else if (i_c0_req && i_c1_req) begin
         w_sel_vld = 1'b1;
         w_sel_id  = ~r_last;
      end else if (i_c0_req) begin
         w_sel_vld = 1'b1;
      end else if (i_c1_req) begin
         w_sel_vld = 1'b1;
         w_sel_id  = 1'b1;
      end
   end

   assign w_sel_we = w_sel_id ? i_c1_we : i_c0_we;
   assign w_gnt    = w_sel_vld & ~i_ram_delay;

   always_comb begin
      o_ram_en     = 1'b0;
      o_ram_we     = 1'b0;
      o_ram_addr   = '0;
      o_ram_be     = '0;
      o_ram_data_w = '0;
      if (w_sel_vld) begin
         o_ram_en     = 1'b1;
         o_ram_we     = w_sel_we;
         o_ram_addr   = w_sel_id ? i_c1_addr  : i_c0_addr;
         o_ram_be     = w_sel_id ? i_c1_be    : i_c0_be;
         o_ram_data_w = w_sel_id ? i_c1_wdata : i_c0_wdata;
      end
   end

   assign o_c0_gnt    = w_gnt & ~w_sel_id;
   assign o_c1_gnt    = w_gnt &  w_sel_id;
   assign o_c0_rvalid = r_rv0 & ~i_reset;
   assign o_c1_rvalid = r_rv1 & ~i_reset;
   assign o_c0_rdata  = i_ram_data_r;
   assign o_c1_rdata  = i_ram_data_r;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last    <= 1'b1;
         r_lock    <= 1'b0;
         r_lock_id <= 1'b0;
         r_rv0     <= 1'b0;
         r_rv1     <= 1'b0;
      end else begin
         r_rv0 <= w_gnt & ~w_sel_id & ~w_sel_we;
         r_rv1 <= w_gnt &  w_sel_id & ~w_sel_we;
         if (w_gnt) begin
            r_last <= w_sel_id;
            r_lock <= 1'b0;
         end else if (w_sel_vld) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_sel_id;
         end
      end
   end

   a_req_held_while_locked: assert property (@(posedge i_clk) disable iff (i_reset)
      r_lock |-> (r_lock_id ? i_c1_req : i_c0_req));
   a_single_read_return: assert property (@(posedge i_clk) disable iff (i_reset)
      !(r_rv0 && r_rv1));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_ram_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          c0_req, c0_we, c1_req, c1_we;
   logic [AW-1:0] c0_addr, c1_addr;
   logic [NB-1:0] c0_be, c1_be;
   logic [DW-1:0] c0_wdata, c1_wdata;
   logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [DW-1:0] c0_rdata, c1_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [NB-1:0] ram_be;
   logic [DW-1:0] ram_data_w;
   logic [DW-1:0] ram_data_r = '0;
   logic          ram_delay;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_c0_req(c0_req), .i_c0_we(c0_we), .i_c0_addr(c0_addr), .i_c0_be(c0_be), .i_c0_wdata(c0_wdata),
      .i_c1_req(c1_req), .i_c1_we(c1_we), .i_c1_addr(c1_addr), .i_c1_be(c1_be), .i_c1_wdata(c1_wdata),
      .o_c0_gnt(c0_gnt), .o_c1_gnt(c1_gnt), .o_c0_rvalid(c0_rvalid), .o_c1_rvalid(c1_rvalid),
      .o_c0_rdata(c0_rdata), .o_c1_rdata(c1_rdata),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_be(ram_be),
      .o_ram_data_w(ram_data_w), .i_ram_data_r(ram_data_r), .i_ram_delay(ram_delay)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   rd_t           q[$];
   logic [DW-1:0] mem [32];
   logic [31:0]   wr_mask = '0;
   logic [DW-1:0] ref_mem [32];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            m_last = 1;
   int            m_stalled = -1;
   bit            g0, g1;
   logic          a_g0, a_g1;

   function automatic logic [DW-1:0] init_val(input logic [4:0] a);
      return (a == 5'h10) ? 32'hDEADBEEF : {4{3'b101, a}};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                           input logic [NB-1:0] be);
      logic [DW-1:0] r;
      r = old_d;
      for (int b = 0; b < NB; b++)
         if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Behavioural RAM: ignores accesses presented while busy.
   always @(posedge clk) begin
      if (ram_en && !ram_delay) begin
         if (ram_we) begin
            mem[ram_addr[4:0]]     <= merge(wr_mask[ram_addr[4:0]] ? mem[ram_addr[4:0]] : init_val(ram_addr[4:0]),
                                            ram_data_w, ram_be);
            wr_mask[ram_addr[4:0]] <= 1'b1;
         end else begin
            ram_data_r <= wr_mask[ram_addr[4:0]] ? mem[ram_addr[4:0]] : init_val(ram_addr[4:0]);
         end
      end
   end

   // Read-return monitor: pops the scoreboard whenever the DUT presents rvalid.
   rd_t e;
   always @(negedge clk) begin
      if (c0_rvalid || c1_rvalid) begin
         if (q.size() == 0) begin
            chk("rv_unexpected", 32'({c1_rvalid, c0_rvalid}), 32'(0));
         end else begin
            e = q.pop_front();
            chk("rv_client", 32'({c1_rvalid, c0_rvalid}), (e.id == 1) ? 32'(2) : 32'(1));
            chk("rv_data", (e.id == 1) ? c1_rdata : c0_rdata, e.data);
            chk("rv_cycle", cyc, e.due);
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         chk("rv_missing", 32'({c1_rvalid, c0_rvalid}), (q[0].id == 1) ? 32'(2) : 32'(1));
         void'(q.pop_front());
      end
   end

   // One clock cycle: predict from the arbitration rules, compare, then advance the model.
   task automatic eval_cycle();
      bit            sel, gnt, we_s;
      int            id;
      logic [AW-1:0] a;
      logic [NB-1:0] be;
      logic [DW-1:0] wd;
      if (rst) q.delete();
      sel = 0;
      id  = 0;
      if (!rst) begin
         if (m_stalled >= 0)            begin sel = 1; id = m_stalled; end
         else if (c0_req && c1_req)     begin sel = 1; id = 1 - m_last; end
         else if (c0_req)               begin sel = 1; id = 0; end
         else if (c1_req)               begin sel = 1; id = 1; end
      end
      gnt  = sel && !ram_delay;
      we_s = (id == 1) ? c1_we : c0_we;
      a    = (id == 1) ? c1_addr : c0_addr;
      be   = (id == 1) ? c1_be : c0_be;
      wd   = (id == 1) ? c1_wdata : c0_wdata;
      @(negedge clk);
      a_g0 = c0_gnt;
      a_g1 = c1_gnt;
      chk("gnt", 32'({c1_gnt, c0_gnt}), 32'({gnt && id == 1, gnt && id == 0}));
      chk("ram_en", 32'(ram_en), 32'(sel));
      chk("ram_we", 32'(ram_we), 32'(sel && we_s));
      chk("ram_addr", ram_addr, sel ? a : '0);
      chk("ram_be", 32'(ram_be), sel ? 32'(be) : 32'(0));
      chk("ram_data_w", ram_data_w, sel ? wd : '0);
      #1;
      g0 = gnt && id == 0;
      g1 = gnt && id == 1;
      if (rst) begin
         m_last    = 1;
         m_stalled = -1;
      end else if (gnt) begin
         m_last    = id;
         m_stalled = -1;
         if (!we_s) q.push_back('{id, ref_mem[a[4:0]], cyc + 1});
         else       ref_mem[a[4:0]] = merge(ref_mem[a[4:0]], wd, be);
      end else if (sel) begin
         m_stalled = id;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rand_req(output logic req, output logic we, output logic [AW-1:0] addr,
                           output logic [NB-1:0] be, output logic [DW-1:0] wd);
      req  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 31));
      be   = NB'($urandom);
      wd   = $urandom;
   endtask

   initial begin
      rst = 1; ram_delay = 0;
      c0_req = 0; c0_we = 0; c0_addr = '0; c0_be = '0; c0_wdata = '0;
      c1_req = 0; c1_we = 0; c1_addr = '0; c1_be = '0; c1_wdata = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(5'(i));
      @(posedge clk);
      #1;
      eval_cycle();
      eval_cycle();
      rst = 0;

      // Lone c0 read of 0x10; data returns next cycle.
      c0_req = 1; c0_we = 0; c0_addr = 32'h10;
      eval_cycle();
      chk("single_gnt", 32'({a_g1, a_g0}), 32'(1));
      c0_req = 0;
      eval_cycle();

      // Contention straight after reset alternates starting with c0.
      rst = 1;
      eval_cycle();
      rst = 0;
      c0_req = 1; c0_addr = 32'h1; c1_req = 1; c1_we = 0; c1_addr = 32'h2;
      for (int i = 0; i < 4; i++) begin
         eval_cycle();
         chk("contention_order", 32'({a_g1, a_g0}), (i % 2 == 1) ? 32'(2) : 32'(1));
      end
      c0_req = 0; c1_req = 0;
      eval_cycle();

      // c1 partial write then read back of the same word.
      c1_req = 1; c1_we = 1; c1_addr = 32'h4; c1_be = 4'b0011; c1_wdata = 32'h12345678;
      eval_cycle();
      c1_we = 0;
      eval_cycle();
      c1_req = 0;
      eval_cycle();

      // Stall: c1 stays locked while c0 joins, then c0 follows.
      c1_req = 1; c1_we = 0; c1_addr = 32'h7; ram_delay = 1;
      eval_cycle();
      c0_req = 1; c0_we = 0; c0_addr = 32'h8;
      eval_cycle();
      eval_cycle();
      chk("stall_no_gnt", 32'({a_g1, a_g0}), 32'(0));
      ram_delay = 0;
      eval_cycle();
      chk("stall_c1_gnt", 32'({a_g1, a_g0}), 32'(2));
      c1_req = 0;
      eval_cycle();
      chk("stall_c0_next", 32'({a_g1, a_g0}), 32'(1));
      c0_req = 0;
      eval_cycle();

      // Reset right after a granted read drops its return.
      c0_req = 1; c0_addr = 32'h3;
      eval_cycle();
      rst = 1; c0_addr = 32'h5; c1_req = 1; c1_addr = 32'h6; c1_we = 0;
      eval_cycle();
      chk("reset_rvalid", 32'({c1_rvalid, c0_rvalid}), 32'(0));
      rst = 0;
      eval_cycle();
      chk("reset_c0_first", 32'({a_g1, a_g0}), 32'(1));
      c0_req = 0;
      eval_cycle();
      c1_req = 0;

      for (int i = 0; i < 5; i++) eval_cycle();

      for (int i = 0; i < 600; i++) begin
         if (!c0_req || g0) rand_req(c0_req, c0_we, c0_addr, c0_be, c0_wdata);
         if (!c1_req || g1) rand_req(c1_req, c1_we, c1_addr, c1_be, c1_wdata);
         rst       = ($urandom_range(0, 79) == 0);
         ram_delay = ($urandom_range(0, 3) == 0);
         eval_cycle();
      end

      rst = 0; ram_delay = 0;
      for (int i = 0; i < 8; i++) begin
         if (g0) c0_req = 0;
         if (g1) c1_req = 0;
         eval_cycle();
      end
      c0_req = 0; c1_req = 0;
      for (int i = 0; i < 3; i++) eval_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM (Ram_if-style client signals) between two requesters, e.g. an instruction-fetch bridge and a data bus bridge.
- Arbitration is round-robin, with a same-cycle grant and single-cycle read return.
- Supports the RAM `delay` stall: a stalled access stays locked to its requester until the RAM takes it.
- Sits between two bus-to-RAM front ends and one RAM instance.

Parameters:
- ADDR_WIDTH, 32, RAM word-address width.
- DATA_WIDTH, 32, RAM data width; multiple of 8.
- NUM_BYTES, DATA_WIDTH/8, byte-enable width (derived, not overridden).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- c0_req, c1_req  in  1 each  access request; held stable with its attributes until granted.
- c0_we, c1_we  in  1 each  1 = write, 0 = read.
- c0_addr, c1_addr  in  ADDR_WIDTH each  word address.
- c0_be, c1_be  in  NUM_BYTES each  byte enables (writes).
- c0_wdata, c1_wdata  in  DATA_WIDTH each  write data.
- c0_gnt, c1_gnt  out  1 each  access accepted this cycle (combinational).
- c0_rvalid, c1_rvalid  out  1 each  read data valid (registered).
- c0_rdata, c1_rdata  out  DATA_WIDTH each  read data; meaningful only with rvalid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_be  out  NUM_BYTES  RAM byte enables.
- ram_data_w  out  DATA_WIDTH  RAM write data.
- ram_data_r  in  DATA_WIDTH  RAM read data; valid the cycle after an accepted read.
- ram_delay  in  1  RAM busy; an access presented while high is not performed.

Behaviour:
- State:
  - last (1 bit): last granted client; reset 1, so client 0 wins first.
  - lock (1 bit) plus lock_id (1 bit): reset 0/0.
  - rv0, rv1 (read-return flags): reset 0.
- Reset: while Reset=1, all gnt=0, ram_en=0, ram_we=0, rvalid=0 regardless of inputs. A transfer in flight is dropped, with no rvalid afterwards.
- Selection (combinational) when lock=0:
  - Exactly one req: that client.
  - Both req: client != last.
  - None: no selection.
- Selection when lock=1: lock_id, even if the other client also requests.
- RAM drive:
  - With a selection: ram_en=1, and ram_we/addr/be/data_w come from the selected client.
  - Without a selection: ram_en=0, ram_we=0, other RAM outputs 0.
- Grant:
  - sel_gnt = selection valid AND ram_delay=0. Only the selected client's gnt is raised; the other's gnt is always 0.
  - Acceptance happens in the same cycle as req; zero added latency.
- On grant: last <= selected id; lock <= 0.
- On stall (selection valid, ram_delay=1): gnt=0; lock <= 1; lock_id <= selected id. The same request is re-presented next cycle, and no reordering is allowed.
- Read return:
  - rvN <= granted read by client N (gnt & !we). rvN is cleared the next cycle unless another read is granted to N.
  - cN_rvalid = rvN; cN_rdata = ram_data_r for both clients, unqualified.
  - Back-to-back reads by one client give continuous rvalid.
  - Alternating grants give alternating rvalid, one cycle after each grant.
- Writes produce no rvalid; gnt is the completion indication.
- ram_delay does not affect read return of an already-accepted read: data is taken the cycle after acceptance.
- req dropped while locked: protocol violation. Assert in simulation (cN_req held until gnt); no recovery behaviour required.
- Only one outstanding read per cycle exists, so rv0 and rv1 are never both 1 (assertion).
- No x propagation: idle outputs are driven to 0.

Test Plan:
- Single client: c0 read addr 0x10 with no c1 activity.
  - Required: c0_gnt=1 in the same cycle; ram_en=1, ram_addr=0x10, ram_we=0.
  - Next cycle: c0_rvalid=1, c0_rdata=ram_data_r (e.g. 0xDEADBEEF); c1_rvalid=0.
- Contention after reset: c0 and c1 both request reads for 4 consecutive cycles (requests re-raised after each grant).
  - Required grants: c0, c1, c0, c1.
  - rvalid alternates c0, c1, c0, c1, one cycle after each grant.
- Write then read: c1 write addr 0x4, be=4'b0011, wdata=0x12345678; next cycle c1 read 0x4.
  - Required: ram_we=1, ram_be=0011, ram_data_w=0x12345678 in cycle 1.
  - Cycle 2: c1_gnt=1 with ram_we=0.
  - Cycle 3: c1_rvalid=1; no rvalid in cycle 2.
- Stall lock: c1 requests alone and ram_delay=1 for 3 cycles; c0 raises req in stall cycle 2.
  - During the stall: ram_en=1 with c1's attributes, all gnt=0.
  - When delay drops: c1_gnt=1, then c0_gnt=1 in the following cycle.
- Reset mid-operation: Reset=1 in the cycle after a granted c0 read.
  - Required: c0_rvalid=0 in that cycle and after.
  - After release with both clients requesting, c0 is granted first (last=1).
- Idle: no requests for 5 cycles.
  - Required: ram_en=0, ram_we=0, ram_addr=0, all gnt/rvalid=0.
